// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared phase encoding, fault indices and transition rules
package traffic_light_pkg;

  typedef enum logic [1:0] {
    DARK   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } phase_t;

  localparam int FLT_PATTERN = 0;
  localparam int FLT_TRANS   = 1;
  localparam int FLT_STUCK   = 2;

  // Only meaningful for from != to; every change not listed as forbidden is allowed.
  function automatic logic legal_transition(phase_t from, phase_t to);
    logic ok;
    ok = 1'b1;
    if (from == YELLOW && to == GREEN)  ok = 1'b0;
    if (from == RED    && to == YELLOW) ok = 1'b0;
    if (from == DARK   && to == RED)    ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lamp input and status outputs of the light monitor
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  import traffic_light_pkg::*;

  logic [0:2]       leds;
  logic             clr_fault;
  phase_t           phase;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] last_len;
  logic             len_valid;
  logic             walk;
  logic             fault;
  logic [2:0]       fault_code;

  modport master (
    output leds, clr_fault,
    input  phase, phase_cnt, last_len, len_valid, walk, fault, fault_code
  );

  modport slave (
    input  leds, clr_fault,
    output phase, phase_cnt, last_len, len_valid, walk, fault, fault_code
  );

endinterface

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - one-hot lamp pattern to phase, flags multi-hot patterns
module tl_phase_decode
  import traffic_light_pkg::*;
(
  input  logic [0:2] leds,
  output phase_t     phase,
  output logic       illegal_pattern
);

  always_comb begin
    phase           = DARK;
    illegal_pattern = 1'b0;
    case (leds)
      3'b000:  phase = DARK;
      3'b100:  phase = GREEN;
      3'b010:  phase = YELLOW;
      3'b001:  phase = RED;
      default: illegal_pattern = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase timer, fault flagger and walk enable
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_PHASE = 200,
  parameter int WALK_DLY  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  traffic_light_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STUCK_AT = CNT_W'(MAX_PHASE - 1);
  localparam logic [CNT_W-1:0] WALK_AT  = CNT_W'(WALK_DLY);

  phase_t           dec_phase;
  logic             illegal;

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             lv_q, lv_d;
  logic [2:0]       fc_q, fc_d;
  logic [2:0]       fault_ev;
  logic             changed;

  tl_phase_decode u_decode (
    .leds            (mon.leds),
    .phase           (dec_phase),
    .illegal_pattern (illegal)
  );

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    last_d   = last_q;
    lv_d     = 1'b0;
    fault_ev = 3'b000;
    changed  = !illegal && (dec_phase != phase_q);

    if (changed) begin
      phase_d = dec_phase;
      cnt_d   = CNT_ONE;
      last_d  = cnt_q;
      lv_d    = 1'b1;
    end

    fault_ev[FLT_PATTERN] = illegal;
    fault_ev[FLT_TRANS]   = changed && !legal_transition(phase_q, dec_phase);
    // Fires only on the step into MAX_PHASE, so saturation never re-triggers it.
    fault_ev[FLT_STUCK]   = !changed && (phase_q != DARK) && (cnt_q == STUCK_AT);

    fc_d = (mon.clr_fault ? 3'b000 : fc_q) | fault_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= DARK;
      cnt_q   <= '0;
      last_q  <= '0;
      lv_q    <= 1'b0;
      fc_q    <= 3'b000;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      lv_q    <= lv_d;
      fc_q    <= fc_d;
    end
  end

  assign mon.phase      = phase_q;
  assign mon.phase_cnt  = cnt_q;
  assign mon.last_len   = last_q;
  assign mon.len_valid  = lv_q;
  assign mon.fault_code = fc_q;
  assign mon.fault      = |fc_q;
  assign mon.walk       = (phase_q == RED) && (cnt_q >= WALK_AT);

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive observer on the `leds[0:2]` output of the intersection light controller, the reading end of the lamp interface. It decodes the lamp pattern into a phase, times each phase in clock cycles, and reports completed phase lengths. It flags illegal lamp patterns, illegal phase sequences and stuck phases, and derives a pedestrian `walk` enable from a stable red. It sits beside the controller in the intersection top level and drives status and pedestrian outputs only; it never feeds back into the controller.

## Interface

Parameters:
- `CNT_W`, 8: width of phase counters.
- `MAX_PHASE`, 200: cycle count at which a non-dark phase is declared stuck. Must be < 2^CNT_W−1.
- `WALK_DLY`, 4: cycles of red before `walk` asserts. Must be 1..MAX_PHASE.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `leds`  in  [0:2]  lamp pattern: bit0 green, bit1 yellow, bit2 red; 000 = dark/attention.
- `clr_fault`  in  1  synchronous clear of sticky fault bits.
- `phase`  out  2  decoded phase: DARK=0, GREEN=1, YELLOW=2, RED=3.
- `phase_cnt`  out  CNT_W  cycles the current phase has been held, saturating.
- `last_len`  out  CNT_W  length of the most recently completed phase.
- `len_valid`  out  1  one-cycle pulse when `last_len` updates.
- `walk`  out  1  pedestrian walk enable.
- `fault`  out  1  OR of `fault_code`.
- `fault_code`  out  3  sticky: bit0 illegal pattern, bit1 illegal transition, bit2 stuck phase.

## Operation

- `leds` is sampled every rising edge with no synchronizer; it comes from the same clock domain.
- Decode: 000→DARK, 100→GREEN, 010→YELLOW, 001→RED. Any multi-hot value is an illegal pattern.
- Illegal pattern: `phase` holds its current value, `phase_cnt` keeps counting, `fault_code[0]` sets.
- Phase change (decoded phase ≠ `phase`):
  - `phase` takes the new value and `phase_cnt` loads 1.
  - `last_len` loads the old `phase_cnt` and `len_valid` pulses.
  - The transition is checked for legality.
- No change: `phase_cnt` increments and saturates at 2^CNT_W−1.
- Legal transitions: GREEN→YELLOW, GREEN→RED (forced red), YELLOW→RED, RED→GREEN, any→DARK, DARK→GREEN, DARK→YELLOW.
- Illegal transitions: YELLOW→GREEN, RED→YELLOW, DARK→RED. Each sets `fault_code[1]`; `phase` still follows `leds`.
- Stuck phase: `fault_code[2]` sets on the edge where `phase` ≠ DARK and `phase_cnt` advances to MAX_PHASE. It does not re-fire while saturated.
- `walk` = (`phase` == RED) && (`phase_cnt` ≥ WALK_DLY). It is combinational from registers and glitch-free because both terms are registered.
- `clr_fault` zeroes `fault_code` at the edge. A fault event in the same cycle wins: that bit is set and the others clear.

## Timing

- Reset values: `phase`=DARK, `phase_cnt`=0, `last_len`=0, `len_valid`=0, `walk`=0, `fault`=0, `fault_code`=000.
- Reset is asserted asynchronously and released synchronously to `clk` by the system reset synchronizer.
- Latency is 1 cycle: `leds` changes before edge k, and `phase`, `phase_cnt`=1, `last_len`, `len_valid` and fault bits are all visible after edge k.
- `len_valid` is high for exactly one cycle per phase change. Back-to-back changes give consecutive pulses with `last_len`=1.
- The first change after reset out of DARK reports the dark duration in `last_len` and is checked like any other transition.
- `walk` drops in the same cycle `phase` leaves RED, and is never high during DARK.
- Reset mid-operation clears everything immediately, including `walk`. No fault is raised for the phase that was interrupted.

## Structure

- `traffic_light_pkg`:
  - `phase_t` enum (DARK, GREEN, YELLOW, RED).
  - Fault bit index constants (`FLT_PATTERN`, `FLT_TRANS`, `FLT_STUCK`).
  - Pure function `legal_transition(phase_t from, phase_t to)`.
- The controller adopts the same enum encoding later.
- One sub-module: `tl_phase_decode`, combinational `leds` → {`phase_t`, `illegal_pattern`}. Reused by the controller bench's scoreboard.
- The rest (counter, fault latches, walk) is flat in `traffic_light_monitor`.

## Test plan

- Reset, hold `leds`=000 for 5 cycles, then 100 → one edge later `phase`=GREEN, `phase_cnt`=1, `len_valid` pulse with `last_len`=5 (counting from reset release edge), `fault`=0.
- WALK_DLY=4: green 10 cycles, yellow 3, red 6 → `last_len` 10, 3, 6; `walk` high for red cycles 4–6 and low on return to green; no faults.
- Yellow then 100 (YELLOW→GREEN) → `fault_code`=010, `phase`=GREEN. Pulse `clr_fault` → 000. Then `clr_fault` in the same cycle as RED→YELLOW → `fault_code` stays 010.
- `leds`=110 during green at `phase_cnt`=7 → `fault_code[0]`=1, `phase` stays GREEN, `phase_cnt`=8 next cycle.
- Hold green 300 cycles → `fault_code[2]` sets when `phase_cnt`=200; `phase_cnt` saturates at 255 and the bit does not re-pulse; DARK held 300 cycles raises no stuck fault.
- Assert `rst_n`=0 mid-red with `walk`=1 → all outputs to reset values without a clock edge. After release, `phase`=DARK and `phase_cnt` counts from 1.
